// File: rtl/pred_rf_param.sv
// Predicate register file with channel route-in, FU write-back, broadcast send and a flash-clear sweep.
// Define PRED_RF_BYPASS_EN to forward same-cycle writes to the read and send ports.
module pred_rf_param #(
    parameter int PW    = 4,
    parameter int DEPTH = 64,
    parameter int NCH   = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NCH*PW-1:0] ch_p_in,
    input  logic [NCH-1:0]    in_sel,
    input  logic [AW-1:0]     in_addr,
    input  logic              wb_we,
    input  logic [AW-1:0]     wb_addr,
    input  logic [PW-1:0]     wb_data,
    input  logic [NCH:0]      fu_sel,
    input  logic [AW-1:0]     rd_addr,
    output logic [PW-1:0]     pred_out,
    output logic              pred_vld,
    input  logic [AW-1:0]     send_addr,
    input  logic [NCH-1:0]    out_en,
    output logic [NCH*PW-1:0] ch_p_out,
    input  logic              clr_req,
    output logic              busy,
    output logic [AW:0]       occ,
    output logic              err
);

    typedef enum logic {S_IDLE, S_CLEAR} state_t;

    state_t          r_state;
    logic            r_busy;
    logic [AW-1:0]   r_clr_addr;
    logic [PW-1:0]   r_data [DEPTH];
    logic [DEPTH-1:0] r_vld;
    logic [AW:0]     r_occ;
    logic            r_err;

    logic [PW-1:0]   w_rt_data;
    logic            w_in_req;
    logic            w_in_one;
    logic            w_collide;
    logic            w_rt_en;
    logic            w_wb_en;
    logic            w_err_nxt;
    logic [1:0]      w_inc;
    logic            w_dec;
    logic [PW-1:0]   w_rd_data;
    logic            w_rd_vld;
    logic [PW-1:0]   w_snd_data;

    // Write arbitration: write-back beats route-in on an address clash; nothing lands while clearing.
    always_comb begin
        w_rt_data = '0;
        for (int k = 0; k < NCH; k++) begin
            if (in_sel[k]) w_rt_data = w_rt_data | ch_p_in[k*PW +: PW];
        end
        w_in_req  = |in_sel;
        w_in_one  = $onehot(in_sel);
        w_collide = wb_we && w_in_one && (wb_addr == in_addr);
        w_rt_en   = !r_busy && w_in_one && !w_collide;
        w_wb_en   = !r_busy && wb_we;
        w_err_nxt = (w_in_req && !w_in_one) || (r_busy && (w_in_req || wb_we)) ||
                    (!r_busy && w_collide);
        w_inc     = {1'b0, w_wb_en && !r_vld[wb_addr]} + {1'b0, w_rt_en && !r_vld[in_addr]};
        w_dec     = r_busy && r_vld[r_clr_addr];
    end

    always_comb begin
        w_rd_data  = r_data[rd_addr];
        w_rd_vld   = r_vld[rd_addr];
        w_snd_data = r_data[send_addr];
`ifdef PRED_RF_BYPASS_EN
        if (w_wb_en && (wb_addr == rd_addr)) begin
            w_rd_data = wb_data;
            w_rd_vld  = 1'b1;
        end else if (w_rt_en && (in_addr == rd_addr)) begin
            w_rd_data = w_rt_data;
            w_rd_vld  = 1'b1;
        end
        if (w_wb_en && (wb_addr == send_addr)) begin
            w_snd_data = wb_data;
        end else if (w_rt_en && (in_addr == send_addr)) begin
            w_snd_data = w_rt_data;
        end
`endif
    end

    always_comb begin
        pred_out = '0;
        pred_vld = 1'b0;
        if ($onehot(fu_sel)) begin
            if (fu_sel[NCH]) begin
                pred_out = w_rd_data;
                pred_vld = w_rd_vld;
            end else begin
                pred_vld = 1'b1;
                for (int k = 0; k < NCH; k++) begin
                    if (fu_sel[k]) pred_out = ch_p_in[k*PW +: PW];
                end
            end
        end
        for (int k = 0; k < NCH; k++) begin
            ch_p_out[k*PW +: PW] = out_en[k] ? w_snd_data : '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_clr_addr <= '0;
            r_vld      <= '0;
            r_occ      <= '0;
            r_err      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
        end else begin
            r_err <= w_err_nxt;
            r_occ <= r_occ + (AW+1)'(w_inc) - (AW+1)'(w_dec);
            if (w_rt_en) begin
                r_data[in_addr] <= w_rt_data;
                r_vld[in_addr]  <= 1'b1;
            end
            if (w_wb_en) begin
                r_data[wb_addr] <= wb_data;
                r_vld[wb_addr]  <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (clr_req) begin
                        r_state    <= S_CLEAR;
                        r_busy     <= 1'b1;
                        r_clr_addr <= '0;
                    end
                end
                S_CLEAR: begin
                    r_data[r_clr_addr] <= '0;
                    r_vld[r_clr_addr]  <= 1'b0;
                    r_clr_addr         <= r_clr_addr + 1'b1;
                    if (r_clr_addr == AW'(DEPTH-1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign occ  = r_occ;
    assign err  = r_err;

endmodule

// File: tb/tb_pred_rf_param.sv
// Directed bench for pred_rf_param (PW=4, DEPTH=64, NCH=4); honours PRED_RF_BYPASS_EN.
module tb_pred_rf_param;

    logic        CLK;
    logic        RST_N;
    logic [15:0] ch_p_in;
    logic [3:0]  in_sel;
    logic [5:0]  in_addr;
    logic        wb_we;
    logic [5:0]  wb_addr;
    logic [3:0]  wb_data;
    logic [4:0]  fu_sel;
    logic [5:0]  rd_addr;
    logic [3:0]  pred_out;
    logic        pred_vld;
    logic [5:0]  send_addr;
    logic [3:0]  out_en;
    logic [15:0] ch_p_out;
    logic        clr_req;
    logic        busy;
    logic [6:0]  occ;
    logic        err;

    int n_cmp  = 0;
    int n_fail = 0;

    pred_rf_param #(.PW(4), .DEPTH(64), .NCH(4)) dut (
        .CLK(CLK), .RST_N(RST_N), .ch_p_in(ch_p_in), .in_sel(in_sel), .in_addr(in_addr),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .fu_sel(fu_sel), .rd_addr(rd_addr),
        .pred_out(pred_out), .pred_vld(pred_vld), .send_addr(send_addr), .out_en(out_en),
        .ch_p_out(ch_p_out), .clr_req(clr_req), .busy(busy), .occ(occ), .err(err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [3:0]  in_sel;
        logic [15:0] ch_in;
        logic [5:0]  in_addr;
        logic        wb_we;
        logic [5:0]  wb_addr;
        logic [3:0]  wb_data;
        logic [4:0]  fu_sel;
        logic [5:0]  rd_addr;
        logic [5:0]  send_addr;
        logic [3:0]  out_en;
        logic [3:0]  e_pred;
        logic        e_vld;
        logic [15:0] e_chout;
        logic [6:0]  e_occ;
        logic        e_err;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ch_p_in = '0; in_sel = '0; in_addr = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
        fu_sel = '0; rd_addr = '0; send_addr = '0; out_en = '0; clr_req = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    logic [3:0]  exp_p;
    logic        exp_v;
    logic [15:0] exp_c;
    int          cyc;

    initial begin
        tbl[0]  = '{4'b0000, 16'h0000, 6'd0,  1'b0, 6'd0,  4'h0, 5'b10000, 6'd0,  6'd0,  4'b1111, 4'h0, 1'b0, 16'h0000, 7'd0, 1'b0};
        tbl[1]  = '{4'b0100, 16'h3A21, 6'd5,  1'b0, 6'd0,  4'h0, 5'b00100, 6'd0,  6'd0,  4'b0000, 4'hA, 1'b1, 16'h0000, 7'd1, 1'b0};
        tbl[2]  = '{4'b0000, 16'h0000, 6'd0,  1'b0, 6'd0,  4'h0, 5'b10000, 6'd5,  6'd5,  4'b0001, 4'hA, 1'b1, 16'h000A, 7'd1, 1'b0};
        tbl[3]  = '{4'b0001, 16'h0003, 6'd9,  1'b1, 6'd9,  4'hC, 5'b00000, 6'd0,  6'd0,  4'b0000, 4'h0, 1'b0, 16'h0000, 7'd2, 1'b1};
        tbl[4]  = '{4'b0000, 16'h0000, 6'd0,  1'b0, 6'd0,  4'h0, 5'b10000, 6'd9,  6'd0,  4'b0000, 4'hC, 1'b1, 16'h0000, 7'd2, 1'b0};
        tbl[5]  = '{4'b0011, 16'h0055, 6'd7,  1'b0, 6'd0,  4'h0, 5'b00011, 6'd0,  6'd0,  4'b0000, 4'h0, 1'b0, 16'h0000, 7'd2, 1'b1};
        tbl[6]  = '{4'b0000, 16'h0000, 6'd0,  1'b0, 6'd0,  4'h0, 5'b10000, 6'd7,  6'd0,  4'b0000, 4'h0, 1'b0, 16'h0000, 7'd2, 1'b0};
        tbl[7]  = '{4'b1000, 16'h7000, 6'd3,  1'b1, 6'd5,  4'h4, 5'b01000, 6'd0,  6'd0,  4'b0000, 4'h7, 1'b1, 16'h0000, 7'd3, 1'b0};
        tbl[8]  = '{4'b0010, 16'h00F0, 6'd11, 1'b1, 6'd10, 4'h1, 5'b10000, 6'd5,  6'd0,  4'b0000, 4'h4, 1'b1, 16'h0000, 7'd5, 1'b0};
        tbl[9]  = '{4'b0000, 16'h0000, 6'd0,  1'b0, 6'd0,  4'h0, 5'b10000, 6'd11, 6'd3,  4'b1011, 4'hF, 1'b1, 16'h7077, 7'd5, 1'b0};
        tbl[10] = '{4'b0001, 16'h0002, 6'd10, 1'b0, 6'd0,  4'h0, 5'b10000, 6'd3,  6'd9,  4'b0100, 4'h7, 1'b1, 16'h0C00, 7'd5, 1'b0};
        tbl[11] = '{4'b0000, 16'h0000, 6'd0,  1'b0, 6'd0,  4'h0, 5'b10000, 6'd10, 6'd10, 4'b1111, 4'h2, 1'b1, 16'h2222, 7'd5, 1'b0};

        idle_inputs();
        RST_N = 1'b0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_occ", 32'(occ), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        RST_N = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            in_sel = tbl[i].in_sel; ch_p_in = tbl[i].ch_in; in_addr = tbl[i].in_addr;
            wb_we = tbl[i].wb_we; wb_addr = tbl[i].wb_addr; wb_data = tbl[i].wb_data;
            fu_sel = tbl[i].fu_sel; rd_addr = tbl[i].rd_addr;
            send_addr = tbl[i].send_addr; out_en = tbl[i].out_en;
            #3;
            chk($sformatf("r%0d_pred", i), 32'(pred_out), 32'(tbl[i].e_pred));
            chk($sformatf("r%0d_vld", i), 32'(pred_vld), 32'(tbl[i].e_vld));
            chk($sformatf("r%0d_chout", i), 32'(ch_p_out), 32'(tbl[i].e_chout));
            tick();
            chk($sformatf("r%0d_occ", i), 32'(occ), 32'(tbl[i].e_occ));
            chk($sformatf("r%0d_err", i), 32'(err), 32'(tbl[i].e_err));
        end
        idle_inputs();

        // Same-cycle write/read on addr 2: first into an invalid entry, then over a valid one.
        wb_we = 1'b1; wb_addr = 6'd2; wb_data = 4'h6;
        fu_sel = 5'b10000; rd_addr = 6'd2; send_addr = 6'd2; out_en = 4'b0001;
        #3;
`ifdef PRED_RF_BYPASS_EN
        exp_p = 4'h6; exp_v = 1'b1; exp_c = 16'h0006;
`else
        exp_p = 4'h0; exp_v = 1'b0; exp_c = 16'h0000;
`endif
        chk("byp1_pred", 32'(pred_out), 32'(exp_p));
        chk("byp1_vld", 32'(pred_vld), 32'(exp_v));
        chk("byp1_chout", 32'(ch_p_out), 32'(exp_c));
        tick();
        chk("byp1_occ", 32'(occ), 32'd6);
        wb_data = 4'h9;
        #3;
`ifdef PRED_RF_BYPASS_EN
        exp_p = 4'h9; exp_c = 16'h0009;
`else
        exp_p = 4'h6; exp_c = 16'h0006;
`endif
        chk("byp2_pred", 32'(pred_out), 32'(exp_p));
        chk("byp2_vld", 32'(pred_vld), 32'd1);
        chk("byp2_chout", 32'(ch_p_out), 32'(exp_c));
        tick();
        wb_we = 1'b0;
        #1;
        chk("byp2_after", 32'(pred_out), 32'h9);
        chk("byp2_occ", 32'(occ), 32'd6);
        idle_inputs();

        // Reset clears a pending err pulse and all stored state.
        in_sel = 4'b0011;
        tick();
        in_sel = 4'b0000;
        chk("multi_err", 32'(err), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        chk("rst2_err", 32'(err), 32'd0);
        chk("rst2_occ", 32'(occ), 32'd0);
        fu_sel = 5'b10000; rd_addr = 6'd5;
        #1;
        chk("rst2_read", 32'({pred_vld, pred_out}), 32'd0);
        #1 RST_N = 1'b1;
        tick();

        // Flash clear with four valid entries.
        for (int i = 0; i < 4; i++) begin
            wb_we = 1'b1; wb_addr = 6'(i); wb_data = 4'(i + 1);
            tick();
        end
        wb_we = 1'b0;
        chk("fill_occ", 32'(occ), 32'd4);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("clr_busy_on", 32'(busy), 32'd1);
        chk("clr_occ0", 32'(occ), 32'd4);
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            wb_we = (cyc == 10); wb_addr = 6'd20; wb_data = 4'h5;
            clr_req = (cyc == 5);
            tick();
            cyc++;
            if (cyc == 2) chk("clr_occ2", 32'(occ), 32'd2);
            if (cyc == 4) chk("clr_occ4", 32'(occ), 32'd0);
            if (cyc == 11) chk("clr_drop_err", 32'(err), 32'd1);
            if (cyc == 12) chk("clr_err_pulse", 32'(err), 32'd0);
        end
        idle_inputs();
        chk("clr_busy_cycles", 32'(cyc), 32'd64);
        chk("clr_done_occ", 32'(occ), 32'd0);
        fu_sel = 5'b10000;
        for (int a = 0; a < 5; a++) begin
            rd_addr = (a == 4) ? 6'd20 : 6'(a);
            #1;
            chk($sformatf("clr_read%0d", rd_addr), 32'({pred_vld, pred_out}), 32'd0);
        end
        tick();

        // Reset mid-sweep, then a fresh sweep must start again at address 0.
        wb_we = 1'b1; wb_addr = 6'd0; wb_data = 4'h5;
        in_sel = 4'b0001; ch_p_in = 16'h0006; in_addr = 6'd1;
        tick();
        idle_inputs();
        wb_we = 1'b1; wb_addr = 6'd40; wb_data = 4'h9;
        tick();
        wb_we = 1'b0;
        chk("ab_fill_occ", 32'(occ), 32'd3);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("ab_mid_busy", 32'(busy), 32'd1);
        chk("ab_mid_occ", 32'(occ), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        chk("ab_rst_busy", 32'(busy), 32'd0);
        chk("ab_rst_occ", 32'(occ), 32'd0);
        #1 RST_N = 1'b1;
        tick();
        wb_we = 1'b1; wb_addr = 6'd0; wb_data = 4'h5;
        in_sel = 4'b0001; ch_p_in = 16'h0006; in_addr = 6'd1;
        tick();
        idle_inputs();
        chk("re_fill_occ", 32'(occ), 32'd2);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        chk("re_busy", 32'(busy), 32'd1);
        tick();
        chk("re_occ_a0", 32'(occ), 32'd1);
        tick();
        chk("re_occ_a1", 32'(occ), 32'd0);
        cyc = 2;
        while (busy === 1'b1 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("re_busy_cycles", 32'(cyc), 32'd64);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
